mem_stage_lsu: RTL and testbench

Parametrised memory-access pipeline stage sitting between the EX and WB stages.
- Replaces the fixed single-cycle MEM stage; supports a split req/data_ok data-SRAM interface, so the stage stalls until the load/store response returns.
- Buffers early response data when WB back-pressures.
- Performs byte/half/word load alignment with sign/zero extension.
- Supports a pipeline flush, discarding responses still owed to cancelled instructions.

---
 rtl/cpu_pkg.sv | 41 ++++
 rtl/mem_stage_lsu_load_align.sv | 34 +++
 rtl/mem_stage_lsu.sv | 137 +++++++++++++
 tb/tb_mem_stage_lsu.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: EX->MS and MS->WS bus layouts and load-op encodings.
package cpu_pkg;

    // Default datapath geometry
    localparam int XLEN_DEF   = 32;
    localparam int PC_W_DEF   = 32;
    localparam int DEST_W_DEF = 5;

    // Bus widths for the default geometry
    localparam int ES_MS_BUS_W = PC_W_DEF + DEST_W_DEF + XLEN_DEF + 6;
    localparam int MS_WS_BUS_W = PC_W_DEF + 1 + DEST_W_DEF + XLEN_DEF;

    // Fixed low-order field offsets in the EX->MS bus (LSB first)
    localparam int MEM_REQ_BIT      = 0;
    localparam int LD_OP_LSB        = 1;
    localparam int RES_FROM_MEM_BIT = 4;
    localparam int ALU_RES_LSB      = 5;

    // Load-op encodings
    typedef enum logic [2:0] {
        LD_W  = 3'd0,
        LD_B  = 3'd1,
        LD_H  = 3'd2,
        LD_BU = 3'd3,
        LD_HU = 3'd4
    } ld_op_e;

    // Offsets of the fields that sit above the XLEN-wide alu_result
    function automatic int dest_lsb(input int xlen);
        return ALU_RES_LSB + xlen;
    endfunction

    function automatic int gr_we_bit(input int xlen, input int dest_w);
        return ALU_RES_LSB + xlen + dest_w;
    endfunction

    function automatic int pc_lsb(input int xlen, input int dest_w);
        return ALU_RES_LSB + xlen + dest_w + 1;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// Load data alignment: selects the addressed byte/half/word and extends it to XLEN.
module load_align
    import cpu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int OFF_W = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0]  data,
    input  logic [OFF_W-1:0] offset,
    input  logic [2:0]       ld_op,
    output logic [XLEN-1:0]  result
);

    logic [XLEN-1:0] shifted;
    logic [7:0]      byte_v;
    logic [15:0]     half_v;

    assign shifted = data >> {offset, 3'b000};
    assign byte_v  = shifted[7:0];
    assign half_v  = shifted[15:0];

    // Extend the selected lane; unknown encodings fall back to the full word
    always_comb begin
        result = data;
        case (ld_op)
            LD_B:    result = XLEN'($signed(byte_v));
            LD_H:    result = XLEN'($signed(half_v));
            LD_BU:   result = XLEN'(byte_v);
            LD_HU:   result = XLEN'(half_v);
            default: result = data;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: waits for split data-SRAM responses, buffers early data
// under WB back-pressure, aligns loads and drains responses owed to flushed work.
module mem_stage_lsu
    import cpu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int PC_W       = 32,
    parameter int DEST_W     = 5,
    parameter int MAX_CANCEL = 3
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          es_to_ms_valid,
    output logic                          ms_allow_in,
    input  logic [PC_W+DEST_W+XLEN+5:0]   es_ms_bus,
    input  logic                          data_sram_data_ok,
    input  logic [XLEN-1:0]               data_sram_rdata,
    input  logic                          ws_allow_in,
    output logic                          ms_to_ws_valid,
    output logic [PC_W+DEST_W+XLEN:0]     ms_ws_bus,
    input  logic                          flush,
    output logic [DEST_W-1:0]             ms_dest_reg,
    output logic [XLEN-1:0]               ms_fwd_data,
    output logic                          ms_fwd_ready
);

    localparam int ES_W  = PC_W + DEST_W + XLEN + 6;
    localparam int OFF_W = $clog2(XLEN / 8);
    localparam int CW    = $clog2(MAX_CANCEL + 1);

    logic              ms_valid;
    logic              data_buf_valid;
    logic [CW-1:0]     cancel_cnt;
    logic [ES_W-1:0]   ms_bus;
    logic [XLEN-1:0]   data_buf;

    logic              mem_req;
    logic [2:0]        ld_op;
    logic              res_from_mem;
    logic [XLEN-1:0]   alu_result;
    logic [DEST_W-1:0] dest;
    logic              gr_we;
    logic [PC_W-1:0]   pc;

    logic              data_ok_live;
    logic              ms_ready_go;
    logic              capture;
    logic              buf_store;
    logic              cancel_inc;
    logic              cancel_dec;
    logic [XLEN-1:0]   load_src;
    logic [XLEN-1:0]   load_result;
    logic [XLEN-1:0]   final_result;

    assign mem_req      = ms_bus[MEM_REQ_BIT];
    assign ld_op        = ms_bus[LD_OP_LSB +: 3];
    assign res_from_mem = ms_bus[RES_FROM_MEM_BIT];
    assign alu_result   = ms_bus[ALU_RES_LSB +: XLEN];
    assign dest         = ms_bus[dest_lsb(XLEN) +: DEST_W];
    assign gr_we        = ms_bus[gr_we_bit(XLEN, DEST_W)];
    assign pc           = ms_bus[pc_lsb(XLEN, DEST_W) +: PC_W];

    // A response only belongs to the current instruction once all cancelled ones are drained
    assign data_ok_live   = data_sram_data_ok && (cancel_cnt == '0);
    assign ms_ready_go    = !mem_req || data_buf_valid || data_ok_live;
    assign ms_allow_in    = !ms_valid || (ms_ready_go && ws_allow_in);
    assign ms_to_ws_valid = ms_valid && ms_ready_go && !flush;

    assign capture   = es_to_ms_valid && ms_allow_in && !flush;
    assign buf_store = data_ok_live && ms_valid && mem_req && !data_buf_valid && !flush
                       && !(ms_to_ws_valid && ws_allow_in);

    assign cancel_inc = flush && ms_valid && mem_req && !data_buf_valid && !data_ok_live;
    assign cancel_dec = data_sram_data_ok && (cancel_cnt != '0);

    assign load_src = data_buf_valid ? data_buf : data_sram_rdata;

    load_align #(
        .XLEN  (XLEN),
        .OFF_W (OFF_W)
    ) u_load_align (
        .data   (load_src),
        .offset (alu_result[OFF_W-1:0]),
        .ld_op  (ld_op),
        .result (load_result)
    );

    assign final_result = res_from_mem ? load_result : alu_result;
    assign ms_ws_bus    = {pc, gr_we, dest, final_result};
    assign ms_dest_reg  = (ms_valid && gr_we) ? dest : '0;
    assign ms_fwd_data  = final_result;
    assign ms_fwd_ready = ms_valid && gr_we && (!res_from_mem || data_buf_valid || data_ok_live);

    // Stage control: valid bit, response-buffer flag and cancelled-response counter
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid       <= 1'b0;
            data_buf_valid <= 1'b0;
            cancel_cnt     <= '0;
        end else begin
            if (flush) begin
                ms_valid <= 1'b0;
            end else if (ms_allow_in) begin
                ms_valid <= es_to_ms_valid;
            end

            if (capture) begin
                data_buf_valid <= 1'b0;
            end else if (buf_store) begin
                data_buf_valid <= 1'b1;
            end

            if (cancel_inc && !cancel_dec) begin
                if (cancel_cnt != CW'(MAX_CANCEL)) begin
                    cancel_cnt <= cancel_cnt + 1'b1;
                end
            end else if (cancel_dec && !cancel_inc) begin
                cancel_cnt <= cancel_cnt - 1'b1;
            end
        end
    end

    // Datapath registers: instruction bus on capture, early response data on buffering
    always_ff @(posedge clk) begin
        if (capture) begin
            ms_bus <= es_ms_bus;
        end
        if (buf_store) begin
            data_buf <= data_sram_rdata;
        end
    end

    // More cancelled responses outstanding than the counter can track is a pipeline bug
    assert property (@(posedge clk) disable iff (!resetn)
                     !(cancel_inc && !cancel_dec && (cancel_cnt == CW'(MAX_CANCEL))));

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed testbench for mem_stage_lsu with explicit comparisons.
module tb_mem_stage_lsu;

  localparam int ES_W = 75;
  localparam int WS_W = 70;
  localparam int TIMEOUT_NS = 100000;

  logic            clk;
  logic            resetn;
  logic            es_to_ms_valid;
  logic            ms_allow_in;
  logic [ES_W-1:0] es_ms_bus;
  logic            data_sram_data_ok;
  logic [31:0]     data_sram_rdata;
  logic            ws_allow_in;
  logic            ms_to_ws_valid;
  logic [WS_W-1:0] ms_ws_bus;
  logic            flush;
  logic [4:0]      ms_dest_reg;
  logic [31:0]     ms_fwd_data;
  logic            ms_fwd_ready;

  int checks = 0;
  int errors = 0;
  bit done   = 1'b0;

  mem_stage_lsu dut (
    .clk               (clk),
    .resetn            (resetn),
    .es_to_ms_valid    (es_to_ms_valid),
    .ms_allow_in       (ms_allow_in),
    .es_ms_bus         (es_ms_bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .ws_allow_in       (ws_allow_in),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_ws_bus         (ms_ws_bus),
    .flush             (flush),
    .ms_dest_reg       (ms_dest_reg),
    .ms_fwd_data       (ms_fwd_data),
    .ms_fwd_ready      (ms_fwd_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [ES_W-1:0] mk(input logic [31:0] pc, input logic we,
                                         input logic [4:0] dest, input logic [31:0] alu,
                                         input logic rfm, input logic [2:0] op,
                                         input logic req);
    return {pc, we, dest, alu, rfm, op, req};
  endfunction

  task automatic fail(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    errors++;
    $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Issue one load, stall for 'waits' cycles, then return rdata and check the result
  task automatic run_load(input string tag, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] rdata, input int waits,
                          input logic [31:0] exp);
    es_ms_bus      = mk(32'h1c000100, 1'b1, 5'd6, addr, 1'b1, op, 1'b1);
    es_to_ms_valid = 1'b1;
    @(posedge clk); #1;
    es_to_ms_valid = 1'b0;
    for (int i = 0; i < waits; i++) begin
      #1;
      checks++;
      if (ms_to_ws_valid !== 1'b0) fail({tag, "_stall_valid"}, ms_to_ws_valid, 1'b0);
      checks++;
      if (ms_allow_in !== 1'b0) fail({tag, "_stall_allow"}, ms_allow_in, 1'b0);
      checks++;
      if (ms_fwd_ready !== 1'b0) fail({tag, "_stall_fwd"}, ms_fwd_ready, 1'b0);
      @(posedge clk); #1;
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = rdata;
    #1;
    checks++;
    if (ms_to_ws_valid !== 1'b1) fail({tag, "_valid"}, ms_to_ws_valid, 1'b1);
    checks++;
    if (ms_ws_bus[31:0] !== exp) fail({tag, "_result"}, ms_ws_bus[31:0], exp);
    @(posedge clk); #1;
    data_sram_data_ok = 1'b0;
  endtask

  initial begin
    #(TIMEOUT_NS);
    if (!done) begin
      errors++;
      $error("FAIL timeout: stimulus did not complete within %0d ns", TIMEOUT_NS);
      $finish;
    end
  end

  initial begin
    clk               = 1'b0;
    resetn            = 1'b0;
    es_to_ms_valid    = 1'b0;
    es_ms_bus         = '0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;
    ws_allow_in       = 1'b1;
    flush             = 1'b0;

    #3;
    checks += 4;
    if (ms_to_ws_valid !== 1'b0 || ms_dest_reg !== 5'd0 ||
        ms_fwd_ready !== 1'b0 || ms_allow_in !== 1'b1) begin
      errors++;
      $error("FAIL reset state: valid=%0b dest=%0h fwd_ready=%0b allow_in=%0b",
             ms_to_ws_valid, ms_dest_reg, ms_fwd_ready, ms_allow_in);
    end
    #9 resetn = 1'b1;
    @(posedge clk); #1;

    // ALU-only instruction
    es_ms_bus      = mk(32'h1c000000, 1'b1, 5'd5, 32'h1234, 1'b0, 3'd0, 1'b0);
    es_to_ms_valid = 1'b1;
    #1;
    checks++;
    if (ms_allow_in !== 1'b1) fail("alu_allow_in", ms_allow_in, 1'b1);
    @(posedge clk); #1;
    es_to_ms_valid = 1'b0;
    #1;
    checks++;
    if (ms_to_ws_valid !== 1'b1) fail("alu_valid", ms_to_ws_valid, 1'b1);
    checks++;
    if (ms_ws_bus !== {32'h1c000000, 1'b1, 5'd5, 32'h00001234})
      fail("alu_bus", ms_ws_bus, {32'h1c000000, 1'b1, 5'd5, 32'h00001234});
    checks++;
    if (ms_dest_reg !== 5'd5) fail("alu_dest", ms_dest_reg, 5'd5);
    checks++;
    if (ms_fwd_ready !== 1'b1) fail("alu_fwd_ready", ms_fwd_ready, 1'b1);
    checks++;
    if (ms_fwd_data !== 32'h00001234) fail("alu_fwd_data", ms_fwd_data, 32'h00001234);
    @(posedge clk); #1;
    checks++;
    if (ms_to_ws_valid !== 1'b0) fail("alu_drained", ms_to_ws_valid, 1'b0);

    // Load alignment variants
    run_load("ld_b_off3",  3'd1, 32'h10000003, 32'h80FF7F01, 2, 32'hFFFFFF80);
    run_load("ld_bu_off3", 3'd3, 32'h10000003, 32'h80FF7F01, 2, 32'h00000080);
    run_load("ld_h_off2",  3'd2, 32'h10000002, 32'h80FF7F01, 1, 32'hFFFF80FF);
    run_load("ld_hu_off2", 3'd4, 32'h10000002, 32'h80FF7F01, 0, 32'h000080FF);
    run_load("ld_hu_off0", 3'd4, 32'h10000000, 32'h80FF7F01, 1, 32'h00007F01);
    run_load("ld_b_off0",  3'd1, 32'h10000000, 32'h80FF7F01, 0, 32'h00000001);
    run_load("ld_w",       3'd0, 32'h10000000, 32'h80FF7F01, 1, 32'h80FF7F01);
    run_load("ld_op7",     3'd7, 32'h10000001, 32'hCAFEF00D, 0, 32'hCAFEF00D);

    // Early data under WB back-pressure is buffered
    es_ms_bus      = mk(32'h1c000200, 1'b1, 5'd7, 32'h100, 1'b1, 3'd0, 1'b1);
    es_to_ms_valid = 1'b1;
    @(posedge clk); #1;
    es_to_ms_valid    = 1'b0;
    ws_allow_in       = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h5A5A5A5A;
    #1;
    checks++;
    if (ms_to_ws_valid !== 1'b1) fail("buf_first_valid", ms_to_ws_valid, 1'b1);
    checks++;
    if (ms_allow_in !== 1'b0) fail("buf_first_allow", ms_allow_in, 1'b0);
    @(posedge clk); #1;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (ms_to_ws_valid !== 1'b1) fail("buf_hold_valid", ms_to_ws_valid, 1'b1);
      checks++;
      if (ms_fwd_data !== 32'h5A5A5A5A) fail("buf_hold_data", ms_fwd_data, 32'h5A5A5A5A);
      checks++;
      if (ms_fwd_ready !== 1'b1) fail("buf_hold_fwd", ms_fwd_ready, 1'b1);
      @(posedge clk); #1;
    end
    ws_allow_in = 1'b1;
    #1;
    checks++;
    if (ms_to_ws_valid !== 1'b1) fail("buf_release_valid", ms_to_ws_valid, 1'b1);
    checks++;
    if (ms_ws_bus !== {32'h1c000200, 1'b1, 5'd7, 32'h5A5A5A5A})
      fail("buf_release_bus", ms_ws_bus, {32'h1c000200, 1'b1, 5'd7, 32'h5A5A5A5A});
    @(posedge clk); #1;
    checks++;
    if (ms_to_ws_valid !== 1'b0) fail("buf_drained", ms_to_ws_valid, 1'b0);

    // Flush while a load is outstanding, then drain the cancelled response
    es_ms_bus      = mk(32'h1c000300, 1'b1, 5'd8, 32'h200, 1'b1, 3'd0, 1'b1);
    es_to_ms_valid = 1'b1;
    @(posedge clk); #1;
    es_to_ms_valid = 1'b0;
    flush          = 1'b1;
    #1;
    checks++;
    if (ms_to_ws_valid !== 1'b0) fail("flush_valid", ms_to_ws_valid, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (dut.cancel_cnt !== 2'd1) fail("flush_cancel_cnt", dut.cancel_cnt, 2'd1);
    checks++;
    if (ms_allow_in !== 1'b1) fail("flush_allow_in", ms_allow_in, 1'b1);
    es_ms_bus      = mk(32'h1c000304, 1'b1, 5'd9, 32'h204, 1'b1, 3'd0, 1'b1);
    es_to_ms_valid = 1'b1;
    @(posedge clk); #1;
    es_to_ms_valid    = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h0000DEAD;
    #1;
    checks++;
    if (ms_to_ws_valid !== 1'b0) fail("cancel_discard_valid", ms_to_ws_valid, 1'b0);
    checks++;
    if (ms_fwd_ready !== 1'b0) fail("cancel_discard_fwd", ms_fwd_ready, 1'b0);
    @(posedge clk); #1;
    data_sram_rdata = 32'h00000011;
    #1;
    checks++;
    if (dut.cancel_cnt !== 2'd0) fail("cancel_cnt_drained", dut.cancel_cnt, 2'd0);
    checks++;
    if (ms_to_ws_valid !== 1'b1) fail("after_cancel_valid", ms_to_ws_valid, 1'b1);
    checks++;
    if (ms_fwd_data !== 32'h00000011) fail("after_cancel_result", ms_fwd_data, 32'h00000011);
    @(posedge clk); #1;
    data_sram_data_ok = 1'b0;

    // Async reset in the middle of a stall with a cancelled response pending
    es_ms_bus      = mk(32'h1c000400, 1'b1, 5'd10, 32'h300, 1'b1, 3'd0, 1'b1);
    es_to_ms_valid = 1'b1;
    @(posedge clk); #1;
    es_to_ms_valid = 1'b0;
    flush          = 1'b1;
    @(posedge clk); #1;
    flush          = 1'b0;
    es_ms_bus      = mk(32'h1c000404, 1'b1, 5'd11, 32'h304, 1'b1, 3'd0, 1'b1);
    es_to_ms_valid = 1'b1;
    @(posedge clk); #1;
    es_to_ms_valid = 1'b0;
    #1;
    checks++;
    if (ms_dest_reg !== 5'd11) fail("pre_rst_dest", ms_dest_reg, 5'd11);
    checks++;
    if (ms_allow_in !== 1'b0) fail("pre_rst_allow", ms_allow_in, 1'b0);
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (ms_to_ws_valid !== 1'b0) fail("async_rst_valid", ms_to_ws_valid, 1'b0);
    checks++;
    if (ms_dest_reg !== 5'd0) fail("async_rst_dest", ms_dest_reg, 5'd0);
    checks++;
    if (ms_fwd_ready !== 1'b0) fail("async_rst_fwd", ms_fwd_ready, 1'b0);
    checks++;
    if (ms_allow_in !== 1'b1) fail("async_rst_allow", ms_allow_in, 1'b1);
    @(posedge clk); #2;
    resetn = 1'b1;
    #1;
    checks++;
    if (dut.cancel_cnt !== 2'd0) fail("post_rst_cancel", dut.cancel_cnt, 2'd0);
    checks++;
    if (ms_allow_in !== 1'b1) fail("post_rst_allow", ms_allow_in, 1'b1);
    @(posedge clk); #1;

    // Back-to-back ALU instructions stream one per cycle
    for (int k = 0; k < 5; k++) begin
      if (k < 4) begin
        es_ms_bus      = mk(32'h1c001000 + 32'(4 * k), 1'b1, 5'(k + 1),
                            32'hA0 + 32'(k), 1'b0, 3'd0, 1'b0);
        es_to_ms_valid = 1'b1;
      end else begin
        es_to_ms_valid = 1'b0;
      end
      #1;
      if (k > 0) begin
        checks++;
        if (ms_to_ws_valid !== 1'b1) fail("b2b_valid", ms_to_ws_valid, 1'b1);
        checks++;
        if (ms_allow_in !== 1'b1) fail("b2b_allow", ms_allow_in, 1'b1);
        checks++;
        if (ms_fwd_ready !== 1'b1) fail("b2b_fwd_ready", ms_fwd_ready, 1'b1);
        checks++;
        if (ms_fwd_data !== 32'hA0 + 32'(k) - 32'd1)
          fail("b2b_fwd_data", ms_fwd_data, 32'hA0 + 32'(k) - 32'd1);
        checks++;
        if (ms_dest_reg !== 5'(k)) fail("b2b_dest", ms_dest_reg, 5'(k));
      end
      @(posedge clk); #1;
    end
    checks++;
    if (ms_to_ws_valid !== 1'b0) fail("b2b_drained", ms_to_ws_valid, 1'b0);

    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
